// File: rtl/gf_pkg.sv
// Shared GF(2^M) constants, constant-function helpers and FSM state type for the
// power-column sequencer. Helpers run at elaboration only.
package gf_pkg;

  localparam int          GF_M_DEF    = 13;
  localparam logic [31:0] GF_POLY_DEF = 32'h0000_201B;
  localparam int          GF_MAX_M    = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bit-serial product a*b modulo poly; poly carries the x^m term so the overflow bit clears itself.
  function automatic logic [31:0] gf_mul(input logic [31:0] a, input logic [31:0] b,
                                         input int m, input logic [31:0] poly);
    logic [31:0] acc;
    logic [31:0] sh;
    acc = 32'd0;
    sh  = a;
    for (int i = 0; i < m; i++) begin
      acc = acc ^ (sh & {32{b[i]}});
      sh  = sh << 1;
      sh  = sh ^ (poly & {32{sh[m]}});
    end
    return acc;
  endfunction

  // alpha^e by square-and-multiply after reducing e modulo the multiplicative group order.
  function automatic logic [31:0] gf_alpha_pow(input int e, input int m, input logic [31:0] poly);
    logic [63:0] ord;
    logic [63:0] e_red;
    logic [31:0] res;
    logic [31:0] base;
    ord   = (64'd1 << m) - 64'd1;
    e_red = 64'(e) % ord;
    res   = 32'd1;
    base  = 32'd2;
    for (int i = 0; i < 32; i++) begin
      res  = e_red[i] ? gf_mul(res, base, m, poly) : res;
      base = gf_mul(base, base, m, poly);
    end
    return res;
  endfunction

  // Column i (bits [i*GF_MAX_M +: GF_MAX_M]) holds alpha^e * x^i.
  function automatic logic [GF_MAX_M*GF_MAX_M-1:0] gf_const_matrix(input int e, input int m,
                                                                    input logic [31:0] poly);
    logic [GF_MAX_M*GF_MAX_M-1:0] mat;
    logic [31:0]                  col;
    mat = {(GF_MAX_M*GF_MAX_M){1'b0}};
    col = gf_alpha_pow(e, m, poly);
    for (int i = 0; i < m; i++) begin
      mat[i*GF_MAX_M +: GF_MAX_M] = col;
      col = gf_mul(col, 32'd2, m, poly);
    end
    return mat;
  endfunction

endpackage

// File: rtl/gf_power_column_seq_if.sv
// Load and beat-stream handshake bundle of the power-column sequencer.
interface gf_power_column_seq_if
  import gf_pkg::*;
#(
  parameter int M     = GF_M_DEF,
  parameter int LANES = 8,
  parameter int CW    = 8
);
  logic                 load_valid;
  logic                 load_ready;
  logic [M-1:0]         load_data;
  logic [CW-1:0]        load_steps;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*M-1:0]   out_data;
  logic [CW-1:0]        out_idx;
  logic                 out_last;
  logic                 busy;

  modport master (
    output load_valid, load_data, load_steps, out_ready,
    input  load_ready, out_valid, out_data, out_idx, out_last, busy
  );

  modport slave (
    input  load_valid, load_data, load_steps, out_ready,
    output load_ready, out_valid, out_data, out_idx, out_last, busy
  );
endinterface

// File: rtl/gf_const_mult.sv
// Combinational multiply by the constant alpha^EXP: a fixed XOR matrix, no tables.
module gf_const_mult
  import gf_pkg::*;
#(
  parameter int          M         = GF_M_DEF,
  parameter logic [31:0] PRIM_POLY = GF_POLY_DEF,
  parameter int          EXP       = 0
) (
  input  logic [M-1:0] x,
  output logic [M-1:0] y
);

  localparam logic [GF_MAX_M*GF_MAX_M-1:0] MAT = gf_const_matrix(EXP, M, PRIM_POLY);

  // XOR together the matrix columns selected by the set bits of x.
  always_comb begin
    y = {M{1'b0}};
    for (int i = 0; i < M; i++) begin
      y = y ^ (MAT[i*GF_MAX_M +: M] & {M{x[i]}});
    end
  end

endmodule

// File: rtl/gf_power_column_seq.sv
// Streams beats of LANES constant-power products of a loaded element b, advancing the
// column by alpha^STEP_EXP per accepted beat.
module gf_power_column_seq
  import gf_pkg::*;
#(
  parameter int          M         = GF_M_DEF,
  parameter logic [31:0] PRIM_POLY = GF_POLY_DEF,
  parameter int          LANES     = 8,
  parameter int          BASE_EXP  = 1,
  parameter int          LANE_EXP  = 1,
  parameter int          STEP_EXP  = 8,
  parameter int          CW        = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  gf_power_column_seq_if.slave bus
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_e               state_r;
  state_e               state_nxt_s;
  logic                 load_run_s;
  logic                 beat_fire_s;
  logic [M-1:0]         r_r;
  logic [M-1:0]         base_s;
  logic [M-1:0]         step_s;
  logic [M-1:0]         r_nxt_s;
  logic [LANES*M-1:0]   lanes_s;
  logic [CW-1:0]        steps_r;
  logic [CW-1:0]        k_r;
  logic [LANES*M-1:0]   out_data_r;
  logic                 out_valid_r;
  logic                 out_last_r;

  gf_const_mult #(.M(M), .PRIM_POLY(PRIM_POLY), .EXP(BASE_EXP)) u_base (
    .x (bus.load_data),
    .y (base_s)
  );

  gf_const_mult #(.M(M), .PRIM_POLY(PRIM_POLY), .EXP(STEP_EXP)) u_step (
    .x (r_r),
    .y (step_s)
  );

  // Lanes are computed from the value r is about to take, so out_data is registered alongside r.
  assign r_nxt_s = load_run_s ? base_s : step_s;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    gf_const_mult #(.M(M), .PRIM_POLY(PRIM_POLY), .EXP(j*LANE_EXP)) u_lane (
      .x (r_nxt_s),
      .y (lanes_s[j*M +: M])
    );
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt_s = state_r;
    load_run_s  = 1'b0;
    beat_fire_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.load_valid && (bus.load_steps != {CW{1'b0}})) begin
          load_run_s  = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        beat_fire_s = out_valid_r && bus.out_ready;
        if (beat_fire_s && out_last_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Column register, beat counter and output bank; all hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r         <= {M{1'b0}};
      steps_r     <= {CW{1'b0}};
      k_r         <= {CW{1'b0}};
      out_data_r  <= {(LANES*M){1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (load_run_s) begin
      r_r         <= base_s;
      steps_r     <= bus.load_steps;
      k_r         <= {CW{1'b0}};
      out_data_r  <= lanes_s;
      out_valid_r <= 1'b1;
      out_last_r  <= (bus.load_steps == CNT_ONE);
    end else if (beat_fire_s) begin
      if (out_last_r) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end else begin
        r_r         <= step_s;
        k_r         <= k_r + CNT_ONE;
        out_data_r  <= lanes_s;
        out_last_r  <= ((k_r + CNT_ONE) == (steps_r - CNT_ONE));
      end
    end else begin
      r_r <= r_r;
    end
  end

  assign bus.load_ready = (state_r == IDLE);
  assign bus.busy       = (state_r != IDLE);
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.out_idx    = k_r;
  assign bus.out_last   = out_last_r;

endmodule

// File: tb/tb_gf_power_column_seq.sv
// Directed bench for gf_power_column_seq: default M=13 instance with hand-computed beats,
// plus an M=14, 32-lane, LANE_EXP=2 instance checked against a software GF multiply.
module tb_gf_power_column_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  gf_power_column_seq_if ifa ();
  gf_power_column_seq_if #(.M(14), .LANES(32), .CW(8)) ifb ();

  gf_power_column_seq u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  gf_power_column_seq #(
    .M(14), .PRIM_POLY(32'h0000_4443), .LANES(32),
    .BASE_EXP(16384), .LANE_EXP(2), .STEP_EXP(64), .CW(8)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  localparam logic [103:0] BEAT0 = {13'h0100, 13'h0080, 13'h0040, 13'h0020,
                                    13'h0010, 13'h0008, 13'h0004, 13'h0002};
  localparam logic [103:0] BEAT1 = {13'h00D8, 13'h006C, 13'h0036, 13'h001B,
                                    13'h1000, 13'h0800, 13'h0400, 13'h0200};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference multiply in GF(2^14) with x^14+x^10+x^6+x+1.
  function automatic logic [13:0] m14_mul(input logic [13:0] a, input logic [13:0] b);
    logic [14:0] sh;
    logic [13:0] acc;
    acc = 14'd0;
    sh  = {1'b0, a};
    for (int i = 0; i < 14; i++) begin
      if (b[i]) acc = acc ^ sh[13:0];
      sh = sh << 1;
      if (sh[14]) sh = sh ^ 15'h4443;
    end
    return acc;
  endfunction

  function automatic logic [13:0] m14_pow(input int e);
    logic [13:0] p;
    p = 14'd1;
    for (int i = 0; i < (e % 16383); i++) p = m14_mul(p, 14'd2);
    return p;
  endfunction

  function automatic logic [447:0] beat_b(input logic [13:0] b, input int k);
    logic [447:0] v;
    v = 448'd0;
    for (int j = 0; j < 32; j++) v[j*14 +: 14] = m14_mul(b, m14_pow(16384 + 2*j + 64*k));
    return v;
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    ifa.load_valid = 1'b0; ifa.load_data = 13'd0; ifa.load_steps = 8'd0; ifa.out_ready = 1'b0;
    ifb.load_valid = 1'b0; ifb.load_data = 14'd0; ifb.load_steps = 8'd0; ifb.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_valid", 512'(ifa.out_valid), 512'(1'b0));
    chk("rst_ready", 512'(ifa.load_ready), 512'(1'b1));
    chk("rst_busy", 512'(ifa.busy), 512'(1'b0));
    chk("rst_data", 512'(ifa.out_data), 512'(104'd0));
    chk("rst_idx", 512'(ifa.out_idx), 512'(8'd0));
    chk("rst_last", 512'(ifa.out_last), 512'(1'b0));
    chk("rst_b_valid", 512'(ifb.out_valid), 512'(1'b0));
    rst_n = 1'b1;
    @(negedge clk);

    // Case 1: b=1, two beats, continuous ready
    ifa.out_ready = 1'b1; ifa.load_data = 13'h0001; ifa.load_steps = 8'd2; ifa.load_valid = 1'b1;
    @(negedge clk);
    ifa.load_valid = 1'b0;
    chk("c1_b0_valid", 512'(ifa.out_valid), 512'(1'b1));
    chk("c1_b0_data", 512'(ifa.out_data), 512'(BEAT0));
    chk("c1_b0_idx", 512'(ifa.out_idx), 512'(8'd0));
    chk("c1_b0_last", 512'(ifa.out_last), 512'(1'b0));
    chk("c1_busy", 512'(ifa.busy), 512'(1'b1));
    chk("c1_load_ready", 512'(ifa.load_ready), 512'(1'b0));
    @(negedge clk);
    chk("c1_b1_data", 512'(ifa.out_data), 512'(BEAT1));
    chk("c1_b1_idx", 512'(ifa.out_idx), 512'(8'd1));
    chk("c1_b1_last", 512'(ifa.out_last), 512'(1'b1));
    @(negedge clk);
    chk("c1_end_valid", 512'(ifa.out_valid), 512'(1'b0));
    chk("c1_end_ready", 512'(ifa.load_ready), 512'(1'b1));
    chk("c1_end_busy", 512'(ifa.busy), 512'(1'b0));

    // Case 3: hold beat0 for three cycles
    ifa.out_ready = 1'b0; ifa.load_valid = 1'b1;
    @(negedge clk);
    ifa.load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("c3_hold_valid", 512'(ifa.out_valid), 512'(1'b1));
      chk("c3_hold_data", 512'(ifa.out_data), 512'(BEAT0));
      chk("c3_hold_idx", 512'(ifa.out_idx), 512'(8'd0));
      if (i < 2) @(negedge clk);
    end
    ifa.out_ready = 1'b1;
    @(negedge clk);
    chk("c3_b1_data", 512'(ifa.out_data), 512'(BEAT1));
    chk("c3_b1_last", 512'(ifa.out_last), 512'(1'b1));

    // Case 5: load held while busy is ignored, then taken one cycle after the last accept
    ifa.load_valid = 1'b1; ifa.load_data = 13'h0001; ifa.load_steps = 8'd1;
    @(negedge clk);
    chk("c5_ignored_valid", 512'(ifa.out_valid), 512'(1'b0));
    chk("c5_idle_ready", 512'(ifa.load_ready), 512'(1'b1));
    chk("c5_idle_busy", 512'(ifa.busy), 512'(1'b0));
    @(negedge clk);
    ifa.load_valid = 1'b0;
    chk("c5_new_valid", 512'(ifa.out_valid), 512'(1'b1));
    chk("c5_new_data", 512'(ifa.out_data), 512'(BEAT0));
    chk("c5_new_last", 512'(ifa.out_last), 512'(1'b1));
    @(negedge clk);
    chk("c5_done_valid", 512'(ifa.out_valid), 512'(1'b0));

    // Case 2: b=0, three zero beats
    ifa.load_data = 13'h0000; ifa.load_steps = 8'd3; ifa.load_valid = 1'b1;
    @(negedge clk);
    ifa.load_valid = 1'b0;
    chk("c2_b0_data", 512'(ifa.out_data), 512'(104'd0));
    chk("c2_b0_valid", 512'(ifa.out_valid), 512'(1'b1));
    chk("c2_b0_last", 512'(ifa.out_last), 512'(1'b0));
    @(negedge clk);
    chk("c2_b1_idx", 512'(ifa.out_idx), 512'(8'd1));
    chk("c2_b1_last", 512'(ifa.out_last), 512'(1'b0));
    @(negedge clk);
    chk("c2_b2_idx", 512'(ifa.out_idx), 512'(8'd2));
    chk("c2_b2_last", 512'(ifa.out_last), 512'(1'b1));
    chk("c2_b2_data", 512'(ifa.out_data), 512'(104'd0));
    @(negedge clk);
    chk("c2_end_valid", 512'(ifa.out_valid), 512'(1'b0));

    // Case 4: zero-step load is accepted and dropped
    ifa.load_data = 13'h1ABC; ifa.load_steps = 8'd0; ifa.load_valid = 1'b1;
    chk("c4_ready", 512'(ifa.load_ready), 512'(1'b1));
    @(negedge clk);
    ifa.load_valid = 1'b0;
    chk("c4_valid", 512'(ifa.out_valid), 512'(1'b0));
    chk("c4_busy", 512'(ifa.busy), 512'(1'b0));
    @(negedge clk);
    chk("c4_valid_later", 512'(ifa.out_valid), 512'(1'b0));

    // Case 6: asynchronous reset mid-job
    ifa.load_data = 13'h0001; ifa.load_steps = 8'd3; ifa.load_valid = 1'b1;
    @(negedge clk);
    ifa.load_valid = 1'b0;
    chk("c6_b0_data", 512'(ifa.out_data), 512'(BEAT0));
    @(negedge clk);
    chk("c6_b1_idx", 512'(ifa.out_idx), 512'(8'd1));
    #2 rst_n = 1'b0;
    #1;
    chk("c6_rst_valid", 512'(ifa.out_valid), 512'(1'b0));
    chk("c6_rst_data", 512'(ifa.out_data), 512'(104'd0));
    chk("c6_rst_idx", 512'(ifa.out_idx), 512'(8'd0));
    chk("c6_rst_busy", 512'(ifa.busy), 512'(1'b0));
    chk("c6_rst_ready", 512'(ifa.load_ready), 512'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    ifa.load_steps = 8'd2; ifa.load_valid = 1'b1;
    @(negedge clk);
    ifa.load_valid = 1'b0;
    chk("c6_fresh_data", 512'(ifa.out_data), 512'(BEAT0));
    chk("c6_fresh_idx", 512'(ifa.out_idx), 512'(8'd0));
    @(negedge clk);
    @(negedge clk);

    // Wide instance: M=14, 32 lanes, LANE_EXP=2, BASE_EXP reduced modulo 16383
    ifb.out_ready = 1'b1; ifb.load_data = 14'h2A5B; ifb.load_steps = 8'd2; ifb.load_valid = 1'b1;
    @(negedge clk);
    ifb.load_valid = 1'b0;
    chk("wb_b0_data", 512'(ifb.out_data), 512'(beat_b(14'h2A5B, 0)));
    chk("wb_b0_last", 512'(ifb.out_last), 512'(1'b0));
    @(negedge clk);
    chk("wb_b1_data", 512'(ifb.out_data), 512'(beat_b(14'h2A5B, 1)));
    chk("wb_b1_last", 512'(ifb.out_last), 512'(1'b1));
    @(negedge clk);
    chk("wb_end_valid", 512'(ifb.out_valid), 512'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
